// File: rtl/acc_cpu_mc_if.sv
// Memory-side bus of the multi-cycle accumulator CPU.
// Groups the instruction-fetch port (req/ack, PC address, AW+4-bit instruction word)
// and the data port (req/ack, write enable, operand address, DW-bit write/read data).
// master: the CPU drives requests; slave: the memory system answers with ack and read data.
interface acc_cpu_mc_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 4
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [AW+3:0] imem_rdata;
    logic          dmem_req;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic          dmem_ack;
    logic [DW-1:0] dmem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/acc_cpu_mc.sv
// Multi-cycle accumulator CPU with a 16-opcode ISA, separate instruction and data
// memory handshakes, and registered zero/carry flags.
// Ports:
//   clk, reset     - rising-edge clock, asynchronous active-high reset
//   run            - 1 = execute, 0 = stop at the next instruction boundary
//   mem            - instruction/data memory bus (master side)
//   pc, acc        - registered program counter and accumulator
//   z_flag, c_flag - registered zero and carry/borrow flags
//   busy           - FSM is not idle
//   retire         - one-cycle pulse in the cycle whose edge completes an instruction
module acc_cpu_mc #(
    parameter int unsigned   DW     = 8,
    parameter int unsigned   AW     = 4,
    parameter logic [AW-1:0] PC_RST = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    acc_cpu_mc_if.master  mem,
    output logic [AW-1:0] pc,
    output logic [DW-1:0] acc,
    output logic          z_flag,
    output logic          c_flag,
    output logic          busy,
    output logic          retire
);
    typedef enum logic [1:0] {StIdle, StFetch, StExec, StMem} state_e;

    typedef enum logic [3:0] {
        OpNop, OpLdac, OpStac, OpMvac, OpMovr, OpJump, OpJmpz, OpJpnz,
        OpAdd, OpSub, OpInac, OpClac, OpAnd, OpOr, OpXor, OpNot
    } op_e;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] ac_q, ac_d;
    logic [DW-1:0] r_q, r_d;
    logic [AW+3:0] ir_q, ir_d;
    logic          z_q, z_d;
    logic          c_q, c_d;

    op_e           op;
    logic [AW-1:0] opnd;
    logic [DW:0]   sum;      // one extra bit carries the carry/borrow out
    logic          write_z;

    assign op   = op_e'(ir_q[AW+3:AW]);
    assign opnd = ir_q[AW-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            pc_q    <= PC_RST;
            ac_q    <= '0;
            r_q     <= '0;
            ir_q    <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ac_q    <= ac_d;
            r_q     <= r_d;
            ir_q    <= ir_d;
            z_q     <= z_d;
            c_q     <= c_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        ac_d           = ac_q;
        r_d            = r_q;
        ir_d           = ir_q;
        z_d            = z_q;
        c_d            = c_q;
        sum            = '0;
        write_z        = 1'b0;
        retire         = 1'b0;
        mem.imem_req   = 1'b0;
        mem.imem_addr  = pc_q;
        mem.dmem_req   = 1'b0;
        mem.dmem_we    = 1'b0;
        mem.dmem_addr  = opnd;
        mem.dmem_wdata = ac_q;

        unique case (state_q)
            StIdle: begin
                if (run) state_d = StFetch;
            end
            StFetch: begin
                mem.imem_req = 1'b1;
                if (mem.imem_ack) begin
                    ir_d    = mem.imem_rdata;
                    pc_d    = pc_q + AW'(1);
                    state_d = StExec;
                end
            end
            StExec: begin
                retire  = 1'b1;
                state_d = run ? StFetch : StIdle;
                case (op)
                    OpNop: ;
                    OpLdac, OpStac: begin
                        retire  = 1'b0;
                        state_d = StMem;
                    end
                    OpMvac: r_d = ac_q;
                    OpMovr: begin
                        ac_d    = r_q;
                        write_z = 1'b1;
                    end
                    OpJump: pc_d = opnd;
                    // pc_q already holds PC+1, so an untaken jump falls through
                    OpJmpz: if (z_q) pc_d = opnd;
                    OpJpnz: if (!z_q) pc_d = opnd;
                    OpAdd, OpSub, OpInac: begin
                        if (op == OpAdd) sum = {1'b0, ac_q} + {1'b0, r_q};
                        else if (op == OpSub) sum = {1'b0, ac_q} - {1'b0, r_q};
                        else sum = {1'b0, ac_q} + (DW+1)'(1);
                        // For SUB the wrapped top bit is set exactly when ac < r
                        ac_d    = sum[DW-1:0];
                        c_d     = sum[DW];
                        write_z = 1'b1;
                    end
                    OpClac: begin
                        ac_d    = '0;
                        write_z = 1'b1;
                    end
                    OpAnd: begin
                        ac_d    = ac_q & r_q;
                        write_z = 1'b1;
                    end
                    OpOr: begin
                        ac_d    = ac_q | r_q;
                        write_z = 1'b1;
                    end
                    OpXor: begin
                        ac_d    = ac_q ^ r_q;
                        write_z = 1'b1;
                    end
                    OpNot: begin
                        ac_d    = ~ac_q;
                        write_z = 1'b1;
                    end
                    default: ;
                endcase
            end
            StMem: begin
                mem.dmem_req = 1'b1;
                mem.dmem_we  = (op == OpStac);
                if (mem.dmem_ack) begin
                    if (op == OpLdac) begin
                        ac_d    = mem.dmem_rdata;
                        write_z = 1'b1;
                    end
                    retire  = 1'b1;
                    state_d = run ? StFetch : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (write_z) z_d = (ac_d == '0);
    end

    assign pc     = pc_q;
    assign acc    = ac_q;
    assign z_flag = z_q;
    assign c_flag = c_q;
    assign busy   = (state_q != StIdle);
endmodule

// File: tb/tb_acc_cpu_mc.sv
module tb_acc_cpu_mc;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic run0 = 1'b0;
    logic run1 = 1'b0;

    always #5 clk = ~clk;

    // DUT 0: DW=8, AW=4 with programmable wait states
    acc_cpu_mc_if #(.DW(8), .AW(4)) if0 ();
    logic [3:0] pc0;
    logic [7:0] acc0;
    logic       z0, c0, busy0, retire0;

    acc_cpu_mc #(.DW(8), .AW(4), .PC_RST(4'h0)) dut0 (
        .clk(clk), .reset(reset), .run(run0), .mem(if0),
        .pc(pc0), .acc(acc0), .z_flag(z0), .c_flag(c0), .busy(busy0), .retire(retire0)
    );

    // DUT 1: DW=16, AW=6, zero-wait memories
    acc_cpu_mc_if #(.DW(16), .AW(6)) if1 ();
    logic [5:0]  pc1;
    logic [15:0] acc1;
    logic        z1, c1, busy1, retire1;

    acc_cpu_mc #(.DW(16), .AW(6), .PC_RST(6'h00)) dut1 (
        .clk(clk), .reset(reset), .run(run1), .mem(if1),
        .pc(pc1), .acc(acc1), .z_flag(z1), .c_flag(c1), .busy(busy1), .retire(retire1)
    );

    // Memory models
    logic [7:0]  imem0 [16];
    logic [7:0]  dmem0 [16];
    logic [9:0]  imem1 [64];
    logic [15:0] dmem1 [64];
    int ilat = 0, dlat = 0;
    int icnt, dcnt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            icnt <= 0;
            dcnt <= 0;
        end else begin
            icnt <= (if0.imem_req && !if0.imem_ack) ? icnt + 1 : 0;
            dcnt <= (if0.dmem_req && !if0.dmem_ack) ? dcnt + 1 : 0;
        end
    end

    assign if0.imem_ack   = if0.imem_req && (icnt >= ilat);
    assign if0.imem_rdata = imem0[if0.imem_addr];
    assign if0.dmem_ack   = if0.dmem_req && (dcnt >= dlat);
    assign if0.dmem_rdata = dmem0[if0.dmem_addr];

    assign if1.imem_ack   = if1.imem_req;
    assign if1.imem_rdata = imem1[if1.imem_addr];
    assign if1.dmem_ack   = if1.dmem_req;
    assign if1.dmem_rdata = dmem1[if1.dmem_addr];

    int checks = 0;
    int failures = 0;

    // Observations per retired instruction of DUT 0
    logic [3:0] obs_pc [64];
    logic [7:0] obs_acc [64];
    logic       obs_z [64];
    logic       obs_c [64];
    int         ret_cyc [64];
    logic [3:0] fetch_addr [64];
    bit         timed_out;
    int         wr_cnt = 0;
    int         stab_err = 0;

    // ISA-level reference model for DUT 0
    logic [3:0] m_pc;
    logic [7:0] m_ac, m_r;
    logic       m_z, m_c;
    logic [7:0] m_dmem [16];

    task automatic model_reset();
        m_pc = 4'h0; m_ac = 8'h00; m_r = 8'h00; m_z = 1'b0; m_c = 1'b0;
        for (int i = 0; i < 16; i++) m_dmem[i] = dmem0[i];
    endtask

    task automatic model_step();
        logic [7:0] ins;
        logic [3:0] op, a;
        int t;
        ins = imem0[m_pc];
        op = ins[7:4];
        a = ins[3:0];
        m_pc = m_pc + 4'd1;
        case (op)
            4'h1: m_ac = m_dmem[a];
            4'h2: m_dmem[a] = m_ac;
            4'h3: m_r = m_ac;
            4'h4: m_ac = m_r;
            4'h5: m_pc = a;
            4'h6: if (m_z) m_pc = a;
            4'h7: if (!m_z) m_pc = a;
            4'h8: begin t = int'(m_ac) + int'(m_r); m_c = (t > 255); m_ac = t[7:0]; end
            4'h9: begin m_c = (m_ac < m_r); m_ac = m_ac - m_r; end
            4'hA: begin t = int'(m_ac) + 1; m_c = (t > 255); m_ac = t[7:0]; end
            4'hB: m_ac = 8'h00;
            4'hC: m_ac = m_ac & m_r;
            4'hD: m_ac = m_ac | m_r;
            4'hE: m_ac = m_ac ^ m_r;
            4'hF: m_ac = ~m_ac;
            default: ;
        endcase
        if (op == 4'h1 || op == 4'h4 || op >= 4'h8) m_z = (m_ac == 8'h00);
    endtask

    task automatic do_reset();
        run0 = 1'b0;
        run1 = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Runs DUT 0 for n retirements, acting as data-memory writer and bus observer.
    task automatic run_prog(input int n, input int budget);
        int k = 0, cyc = 0, nf = 0;
        bit pend = 0, dpend = 0, ipend = 0;
        logic [3:0] s_da, s_ia;
        logic       s_we;
        logic [7:0] s_wd;
        timed_out = 1'b0;
        while (k < n) begin
            @(negedge clk);
            cyc++;
            if (pend) begin
                obs_pc[k] = pc0; obs_acc[k] = acc0; obs_z[k] = z0; obs_c[k] = c0;
                k++;
                pend = 0;
                if (k == n) break;
            end
            if (dpend && (!if0.dmem_req || if0.dmem_addr != s_da || if0.dmem_we != s_we ||
                          if0.dmem_wdata != s_wd)) stab_err++;
            if (ipend && (!if0.imem_req || if0.imem_addr != s_ia)) stab_err++;
            dpend = if0.dmem_req && !if0.dmem_ack;
            s_da = if0.dmem_addr; s_we = if0.dmem_we; s_wd = if0.dmem_wdata;
            ipend = if0.imem_req && !if0.imem_ack;
            s_ia = if0.imem_addr;
            if (if0.imem_req && if0.imem_ack && nf < 64) begin
                fetch_addr[nf] = if0.imem_addr;
                nf++;
            end
            if (if0.dmem_req && if0.dmem_ack && if0.dmem_we) begin
                dmem0[if0.dmem_addr] = if0.dmem_wdata;
                wr_cnt++;
            end
            if (retire0) begin
                ret_cyc[k] = cyc;
                pend = 1;
            end
            if (cyc >= budget) begin
                timed_out = 1'b1;
                break;
            end
        end
    endtask

    task automatic load_prog0(input logic [7:0] fill);
        for (int i = 0; i < 16; i++) begin
            imem0[i] = fill;
            dmem0[i] = 8'h00;
        end
    endtask

    task automatic test_reset();
        load_prog0(8'hA0);
        ilat = 0; dlat = 0;
        do_reset();
        run0 = 1'b1;
        repeat (7) @(negedge clk);
        ilat = 100;
        repeat (4) @(negedge clk);
        checks++; if (imem_req_now() !== 1'b1) begin failures++;
            $display("FAIL reset_pre_req got %0b expected 1", if0.imem_req); end
        checks++; if (acc0 === 8'h00) begin failures++;
            $display("FAIL reset_pre_acc got %0h expected nonzero", acc0); end
        #3 reset = 1'b1;
        #1;
        checks++; if (if0.imem_req !== 1'b0) begin failures++;
            $display("FAIL reset_req got %0b expected 0", if0.imem_req); end
        checks++; if (pc0 !== 4'h0) begin failures++;
            $display("FAIL reset_pc got %0h expected 0", pc0); end
        checks++; if (acc0 !== 8'h00) begin failures++;
            $display("FAIL reset_acc got %0h expected 0", acc0); end
        checks++; if ({z0, c0, busy0, retire0} !== 4'b0000) begin failures++;
            $display("FAIL reset_flags got %b expected 0000", {z0, c0, busy0, retire0}); end
        @(negedge clk);
        ilat = 0;
        run0 = 1'b0;
        reset = 1'b0;
    endtask

    function automatic logic imem_req_now();
        return if0.imem_req;
    endfunction

    task automatic test_zero_wait();
        load_prog0(8'h00);
        imem0[1] = 8'h18; imem0[2] = 8'h30; imem0[3] = 8'hA0; imem0[4] = 8'h80;
        dmem0[8] = 8'hFF;
        ilat = 0; dlat = 0;
        do_reset();
        run0 = 1'b1;
        run_prog(5, 100);
        run0 = 1'b0;
        checks++; if (timed_out !== 1'b0) begin failures++;
            $display("FAIL zw_timeout got %0b expected 0", timed_out); end
        checks++; if (ret_cyc[1] - ret_cyc[0] !== 3) begin failures++;
            $display("FAIL zw_ldac_cycles got %0d expected 3", ret_cyc[1] - ret_cyc[0]); end
        for (int i = 2; i < 5; i++) begin
            checks++; if (ret_cyc[i] - ret_cyc[i-1] !== 2) begin failures++;
                $display("FAIL zw_cycles_%0d got %0d expected 2", i, ret_cyc[i] - ret_cyc[i-1]); end
        end
        checks++; if (obs_acc[1] !== 8'hFF) begin failures++;
            $display("FAIL zw_ldac_acc got %0h expected ff", obs_acc[1]); end
        checks++; if ({obs_acc[3], obs_z[3], obs_c[3]} !== {8'h00, 1'b1, 1'b1}) begin failures++;
            $display("FAIL zw_inac got acc=%0h z=%0b c=%0b expected acc=0 z=1 c=1",
                     obs_acc[3], obs_z[3], obs_c[3]); end
        checks++; if ({obs_acc[4], obs_z[4], obs_c[4]} !== {8'hFF, 1'b0, 1'b0}) begin failures++;
            $display("FAIL zw_add got acc=%0h z=%0b c=%0b expected acc=ff z=0 c=0",
                     obs_acc[4], obs_z[4], obs_c[4]); end
    endtask

    task automatic test_sub_jump();
        load_prog0(8'h00);
        imem0[0] = 8'h1E; imem0[1] = 8'h30; imem0[2] = 8'h1F;
        imem0[3] = 8'h90; imem0[4] = 8'h60; imem0[5] = 8'h70;
        dmem0[14] = 8'h05; dmem0[15] = 8'h03;
        do_reset();
        run0 = 1'b1;
        run_prog(6, 100);
        run0 = 1'b0;
        checks++; if (timed_out !== 1'b0) begin failures++;
            $display("FAIL sub_timeout got %0b expected 0", timed_out); end
        checks++; if ({obs_acc[3], obs_z[3], obs_c[3]} !== {8'hFE, 1'b0, 1'b1}) begin failures++;
            $display("FAIL sub_result got acc=%0h z=%0b c=%0b expected acc=fe z=0 c=1",
                     obs_acc[3], obs_z[3], obs_c[3]); end
        checks++; if (obs_pc[4] !== 4'h5) begin failures++;
            $display("FAIL jmpz_not_taken got pc=%0h expected 5", obs_pc[4]); end
        checks++; if (obs_pc[5] !== 4'h0) begin failures++;
            $display("FAIL jpnz_taken got pc=%0h expected 0", obs_pc[5]); end
    endtask

    task automatic test_wait_states();
        int wbase, sbase;
        load_prog0(8'h00);
        imem0[0] = 8'hA0; imem0[1] = 8'hA0; imem0[2] = 8'hA0; imem0[3] = 8'h29;
        ilat = 3; dlat = 2;
        do_reset();
        wbase = wr_cnt; sbase = stab_err;
        run0 = 1'b1;
        run_prog(5, 200);
        run0 = 1'b0;
        checks++; if (timed_out !== 1'b0) begin failures++;
            $display("FAIL ws_timeout got %0b expected 0", timed_out); end
        checks++; if (ret_cyc[1] - ret_cyc[0] !== 5) begin failures++;
            $display("FAIL ws_inac_cycles got %0d expected 5", ret_cyc[1] - ret_cyc[0]); end
        checks++; if (ret_cyc[3] - ret_cyc[2] !== 8) begin failures++;
            $display("FAIL ws_stac_cycles got %0d expected 8", ret_cyc[3] - ret_cyc[2]); end
        checks++; if (wr_cnt - wbase !== 1) begin failures++;
            $display("FAIL ws_write_count got %0d expected 1", wr_cnt - wbase); end
        checks++; if (dmem0[9] !== 8'h03) begin failures++;
            $display("FAIL ws_write_data got %0h expected 3", dmem0[9]); end
        checks++; if (stab_err - sbase !== 0) begin failures++;
            $display("FAIL ws_bus_stable got %0d changes expected 0", stab_err - sbase); end
        ilat = 0; dlat = 0;
    endtask

    task automatic test_pc_wrap();
        load_prog0(8'h00);
        do_reset();
        run0 = 1'b1;
        run_prog(17, 200);
        run0 = 1'b0;
        checks++; if (timed_out !== 1'b0) begin failures++;
            $display("FAIL wrap_timeout got %0b expected 0", timed_out); end
        checks++; if (fetch_addr[15] !== 4'hF || fetch_addr[16] !== 4'h0) begin failures++;
            $display("FAIL wrap_fetch got %0h,%0h expected f,0", fetch_addr[15], fetch_addr[16]); end
        checks++; if (obs_pc[15] !== 4'h0) begin failures++;
            $display("FAIL wrap_pc got %0h expected 0", obs_pc[15]); end
    endtask

    task automatic test_run_stop();
        bit found, seen;
        load_prog0(8'h00);
        imem0[1] = 8'h17; imem0[2] = 8'hA0;
        dmem0[7] = 8'h42;
        dlat = 3;
        do_reset();
        run0 = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = if0.dmem_req;
        end
        checks++; if (found !== 1'b1) begin failures++;
            $display("FAIL stop_reach_mem got %0b expected 1", found); end
        run0 = 1'b0;
        found = retire0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            found = retire0;
        end
        checks++; if (found !== 1'b1) begin failures++;
            $display("FAIL stop_retire got %0b expected 1", found); end
        @(negedge clk);
        checks++; if ({acc0, pc0, busy0} !== {8'h42, 4'h2, 1'b0}) begin failures++;
            $display("FAIL stop_state got acc=%0h pc=%0h busy=%0b expected acc=42 pc=2 busy=0",
                     acc0, pc0, busy0); end
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (if0.imem_req || busy0) seen = 1;
        end
        checks++; if (seen !== 1'b0) begin failures++;
            $display("FAIL stop_idle got activity=%0b expected 0", seen); end
        run0 = 1'b1;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            found = retire0;
        end
        @(negedge clk);
        checks++; if ({found, acc0, pc0} !== {1'b1, 8'h43, 4'h3}) begin failures++;
            $display("FAIL resume got retire=%0b acc=%0h pc=%0h expected retire=1 acc=43 pc=3",
                     found, acc0, pc0); end
        run0 = 1'b0;
        dlat = 0;
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 16; i++) begin
                imem0[i] = 8'($urandom);
                dmem0[i] = 8'($urandom);
            end
            ilat = $urandom_range(0, 2);
            dlat = $urandom_range(0, 2);
            do_reset();
            model_reset();
            run0 = 1'b1;
            run_prog(40, 1000);
            run0 = 1'b0;
            checks++; if (timed_out !== 1'b0) begin failures++;
                $display("FAIL rand%0d_timeout got %0b expected 0", it, timed_out); end
            for (int k = 0; k < 40; k++) begin
                model_step();
                checks++;
                if (obs_pc[k] !== m_pc || obs_acc[k] !== m_ac || obs_z[k] !== m_z ||
                    obs_c[k] !== m_c) begin
                    failures++;
                    $display("FAIL rand%0d_instr%0d got pc=%0h acc=%0h z=%0b c=%0b expected pc=%0h acc=%0h z=%0b c=%0b",
                             it, k, obs_pc[k], obs_acc[k], obs_z[k], obs_c[k], m_pc, m_ac, m_z, m_c);
                end
            end
            for (int i = 0; i < 16; i++) begin
                checks++; if (dmem0[i] !== m_dmem[i]) begin failures++;
                    $display("FAIL rand%0d_dmem%0d got %0h expected %0h", it, i, dmem0[i], m_dmem[i]); end
            end
        end
        ilat = 0; dlat = 0;
    endtask

    task automatic test_param_sweep();
        logic [5:0]  o_pc [6];
        logic [15:0] o_acc [6];
        logic        o_z [6];
        logic        o_c [6];
        int k;
        bit pend, saw3f;
        for (int i = 0; i < 64; i++) begin
            imem1[i] = 10'h000;
            dmem1[i] = 16'h0000;
        end
        imem1[0] = 10'h050; imem1[1] = 10'h0C0; imem1[2] = 10'h051;
        imem1[3] = 10'h200; imem1[4] = 10'h17F;
        dmem1[16] = 16'hFFFF; dmem1[17] = 16'h0001;
        do_reset();
        run1 = 1'b1;
        k = 0; pend = 0; saw3f = 0;
        for (int cyc = 0; cyc < 100 && k < 6; cyc++) begin
            @(negedge clk);
            if (pend) begin
                o_pc[k] = pc1; o_acc[k] = acc1; o_z[k] = z1; o_c[k] = c1;
                k++;
                pend = 0;
            end
            if (if1.imem_req && if1.imem_ack && if1.imem_addr == 6'h3F) saw3f = 1;
            if (retire1 && k < 6) pend = 1;
        end
        run1 = 1'b0;
        checks++; if (k !== 6) begin failures++;
            $display("FAIL p16_retired got %0d expected 6", k); end
        if (k == 6) begin
            checks++; if ({o_acc[3], o_z[3], o_c[3]} !== {16'h0000, 1'b1, 1'b1}) begin failures++;
                $display("FAIL p16_add got acc=%0h z=%0b c=%0b expected acc=0 z=1 c=1",
                         o_acc[3], o_z[3], o_c[3]); end
            checks++; if (o_pc[4] !== 6'h3F) begin failures++;
                $display("FAIL p16_jump got pc=%0h expected 3f", o_pc[4]); end
            checks++; if (o_pc[5] !== 6'h00) begin failures++;
                $display("FAIL p16_wrap got pc=%0h expected 0", o_pc[5]); end
        end
        checks++; if (saw3f !== 1'b1) begin failures++;
            $display("FAIL p16_fetch_3f got %0b expected 1", saw3f); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_sub_jump();
        test_wait_states();
        test_pc_wrap();
        test_run_stop();
        test_random();
        test_param_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
